leaf_router_n: RTL

LEAF_ROUTER_N -- requirements
Module: leaf_router_n

---
 rtl/noc_pkg.sv | 19 +
 rtl/leaf_router_n_if.sv | 32 +++
 rtl/noc_sync_fifo.sv | 49 ++++
 rtl/leaf_router_n.sv | 154 +++++++++++++++
 4 files changed

// File: rtl/noc_pkg.sv
// Shared NoC definitions: default flit geometry and destination-field extraction.
package noc_pkg;

   localparam int unsigned DEF_DWIDTH = 16;
   localparam int unsigned DEF_ADDR_W = 6;
   localparam int unsigned MAX_DWIDTH = 64;

   typedef logic [MAX_DWIDTH-1:0] flit_wide_t;

   // Flit is zero-extended to MAX_DWIDTH; the result holds dest in its low addr_w bits.
   function automatic flit_wide_t dest_field(input flit_wide_t  flit,
                                             input int unsigned dwidth,
                                             input int unsigned addr_w);
      flit_wide_t mask;
      mask = (flit_wide_t'(1) << addr_w) - flit_wide_t'(1);
      return (flit >> (dwidth - addr_w)) & mask;
   endfunction

endpackage

// File: rtl/leaf_router_n_if.sv
// Valid/ready bundle for the leaf router: local NI port plus flattened spine ports.
interface leaf_router_n_if #(
   parameter int unsigned DWIDTH     = 16,
   parameter int unsigned NUM_SPINES = 4
);
   logic [DWIDTH-1:0]            local_in_data;
   logic                         local_in_valid;
   logic                         local_in_ready;
   logic [DWIDTH-1:0]            local_out_data;
   logic                         local_out_valid;
   logic                         local_out_ready;
   logic [NUM_SPINES*DWIDTH-1:0] spine_in_data;
   logic [NUM_SPINES-1:0]        spine_in_valid;
   logic [NUM_SPINES-1:0]        spine_in_ready;
   logic [NUM_SPINES*DWIDTH-1:0] spine_out_data;
   logic [NUM_SPINES-1:0]        spine_out_valid;
   logic [NUM_SPINES-1:0]        spine_out_ready;

   modport slave (
      input  local_in_data, local_in_valid, local_out_ready,
      input  spine_in_data, spine_in_valid, spine_out_ready,
      output local_in_ready, local_out_data, local_out_valid,
      output spine_in_ready, spine_out_data, spine_out_valid
   );

   modport master (
      output local_in_data, local_in_valid, local_out_ready,
      output spine_in_data, spine_in_valid, spine_out_ready,
      input  local_in_ready, local_out_data, local_out_valid,
      input  spine_in_ready, spine_out_data, spine_out_valid
   );
endinterface

// File: rtl/noc_sync_fifo.sv
// Synchronous FIFO with combinational head (no write-to-read bypass) and occupancy count.
module noc_sync_fifo
   import noc_pkg::*;
#(
   parameter  int unsigned DWIDTH     = DEF_DWIDTH,
   parameter  int unsigned FIFO_DEPTH = 4,
   localparam int unsigned AW         = $clog2(FIFO_DEPTH),
   localparam int unsigned CW         = AW + 1
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              push,
   input  logic [DWIDTH-1:0] push_data,
   input  logic              pop,
   output logic [DWIDTH-1:0] pop_data,
   output logic              full,
   output logic              empty,
   output logic [CW-1:0]     count
);
   logic [DWIDTH-1:0] mem [FIFO_DEPTH];
   logic [AW-1:0]     wr_ptr, rd_ptr;
   logic              do_push, do_pop;

   always_comb begin
      full     = (count == CW'(FIFO_DEPTH));
      empty    = (count == '0);
      pop_data = mem[rd_ptr];
      do_push  = push && !full;
      do_pop   = pop && !empty;
   end

   // Pointers are exactly AW bits wide, so wrap modulo FIFO_DEPTH is free.
   always_ff @(posedge clk) begin
      if (reset) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push) begin
            mem[wr_ptr] <= push_data;
            wr_ptr      <= wr_ptr + AW'(1);
         end
         if (do_pop) begin
            rd_ptr <= rd_ptr + AW'(1);
         end
         count <= count + CW'(do_push) - CW'(do_pop);
      end
   end
endmodule

// File: rtl/leaf_router_n.sv
// Leaf router: local flits fan out to spines by dest low bits; spine flits for this
// leaf share local_out via round-robin; misrouted flits are dropped and counted.
module leaf_router_n
   import noc_pkg::*;
#(
   parameter  int unsigned DWIDTH     = DEF_DWIDTH,
   parameter  int unsigned NUM_SPINES = 4,
   parameter  int unsigned FIFO_DEPTH = 4,
   parameter  int unsigned ADDR_W     = DEF_ADDR_W,
   parameter  int unsigned ROUTER_ID  = 4,
   localparam int unsigned SW         = $clog2(NUM_SPINES)
) (
   input  logic           clk,
   input  logic           reset,
   leaf_router_n_if.slave bus,
   output logic [15:0]    drop_count,
   output logic [SW-1:0]  grant_idx
);
   localparam int unsigned NF = NUM_SPINES + 1;
   localparam int unsigned CW = $clog2(FIFO_DEPTH) + 1;

   // FIFO slot 0 is the local input; slot k+1 is spine k.
   logic [DWIDTH-1:0]     f_in_data [NF];
   logic [DWIDTH-1:0]     f_head    [NF];
   logic [CW-1:0]         f_count   [NF];
   logic [NF-1:0]         f_in_valid, f_push, f_pop, f_full, f_empty, f_ready;

   logic [DWIDTH-1:0]     lo_data, g_data;
   logic [DWIDTH-1:0]     so_data [NUM_SPINES];
   logic                  lo_valid, lo_ok, gnt, l_drop, l_go;
   logic [NUM_SPINES-1:0] so_valid, so_load, s_elig, s_drop;
   logic [SW-1:0]         rr_ptr, gnt_k, cand, l_tgt;
   logic [4:0]            n_drop;
   logic [16:0]           drop_sum;
   flit_wide_t            l_dest, s_dest;

   always_comb begin
      f_in_data[0]  = bus.local_in_data;
      f_in_valid[0] = bus.local_in_valid;
      for (int unsigned k = 0; k < NUM_SPINES; k++) begin
         f_in_data[k+1]  = bus.spine_in_data[k*DWIDTH +: DWIDTH];
         f_in_valid[k+1] = bus.spine_in_valid[k];
      end
   end

   // Ready is held low for the whole reset cycle, then tracks occupancy.
   always_comb begin
      for (int unsigned i = 0; i < NF; i++) begin
         f_ready[i] = !reset && (f_count[i] != CW'(FIFO_DEPTH));
         f_push[i]  = f_in_valid[i] && !f_full[i];
      end
      bus.local_in_ready = f_ready[0];
      bus.spine_in_ready = f_ready[NF-1:1];
   end

   for (genvar i = 0; i < NF; i++) begin : g_fifo
      noc_sync_fifo #(
         .DWIDTH     (DWIDTH),
         .FIFO_DEPTH (FIFO_DEPTH)
      ) u_fifo (
         .clk       (clk),
         .reset     (reset),
         .push      (f_push[i]),
         .push_data (f_in_data[i]),
         .pop       (f_pop[i]),
         .pop_data  (f_head[i]),
         .full      (f_full[i]),
         .empty     (f_empty[i]),
         .count     (f_count[i])
      );
   end

   always_comb begin
      l_dest  = dest_field(flit_wide_t'(f_head[0]), DWIDTH, ADDR_W);
      l_tgt   = l_dest[SW-1:0];
      l_drop  = !f_empty[0] && (l_dest == flit_wide_t'(ROUTER_ID));
      l_go    = !f_empty[0] && !l_drop
                && (!so_valid[l_tgt] || bus.spine_out_ready[l_tgt]);
      so_load = '0;
      so_load[l_tgt] = l_go;

      s_dest = '0;
      s_elig = '0;
      s_drop = '0;
      for (int unsigned k = 0; k < NUM_SPINES; k++) begin
         s_dest    = dest_field(flit_wide_t'(f_head[k+1]), DWIDTH, ADDR_W);
         s_elig[k] = !f_empty[k+1] && (s_dest == flit_wide_t'(ROUTER_ID));
         s_drop[k] = !f_empty[k+1] && (s_dest != flit_wide_t'(ROUTER_ID));
      end

      // First eligible spine scanning upward from rr_ptr, wrapping on SW bits.
      lo_ok = !lo_valid || bus.local_out_ready;
      gnt   = 1'b0;
      gnt_k = '0;
      cand  = '0;
      for (int unsigned off = 0; off < NUM_SPINES; off++) begin
         cand = rr_ptr + SW'(off);
         if (lo_ok && !gnt && s_elig[cand]) begin
            gnt   = 1'b1;
            gnt_k = cand;
         end
      end

      g_data   = '0;
      f_pop[0] = l_drop || l_go;
      n_drop   = 5'(l_drop);
      for (int unsigned k = 0; k < NUM_SPINES; k++) begin
         f_pop[k+1] = s_drop[k] || (gnt && gnt_k == SW'(k));
         if (gnt && gnt_k == SW'(k)) g_data = f_head[k+1];
         n_drop = n_drop + 5'(s_drop[k]);
      end
      drop_sum = {1'b0, drop_count} + 17'(n_drop);
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         lo_data    <= '0;
         lo_valid   <= 1'b0;
         so_valid   <= '0;
         rr_ptr     <= '0;
         grant_idx  <= '0;
         drop_count <= '0;
         for (int unsigned k = 0; k < NUM_SPINES; k++) so_data[k] <= '0;
      end else begin
         if (gnt) begin
            lo_data   <= g_data;
            lo_valid  <= 1'b1;
            rr_ptr    <= gnt_k + SW'(1);
            grant_idx <= gnt_k;
         end else if (bus.local_out_ready) begin
            lo_valid <= 1'b0;
         end
         for (int unsigned k = 0; k < NUM_SPINES; k++) begin
            if (so_load[k]) begin
               so_data[k]  <= f_head[0];
               so_valid[k] <= 1'b1;
            end else if (bus.spine_out_ready[k]) begin
               so_valid[k] <= 1'b0;
            end
         end
         drop_count <= drop_sum[16] ? '1 : drop_sum[15:0];
      end
   end

   always_comb begin
      bus.local_out_data  = lo_data;
      bus.local_out_valid = lo_valid;
      bus.spine_out_valid = so_valid;
      bus.spine_out_data  = '0;
      for (int unsigned k = 0; k < NUM_SPINES; k++) begin
         bus.spine_out_data[k*DWIDTH +: DWIDTH] = so_data[k];
      end
   end
endmodule
